char_rx: RTL and testbench
==========================

CHAR_RX -- requirements
Module: char_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are even and >= 4.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; asserting it clears all state immediately, independent of clk.
REQ-004 rx  input  1  serial line, idle high, 8N1 framing, LSB first; asynchronous to clk.
REQ-005 char  output  8  last correctly received byte; held stable between receptions; drives the char input of the downstream identifier FSM.
REQ-006 char_valid  output  1  one-cycle pulse, high in the same cycle that char first shows a new byte.
REQ-007 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 busy  output  1  high in every state except IDLE.

Function
REQ-009 rx SHALL pass through a two-flop synchronizer; only the synchronized value (rx_s) is used internally.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP and RECOVER; there SHALL be no other reachable state.
REQ-011 One cycle counter (0..CLKS_PER_BIT-1) and a 3-bit bit index SHALL time the frame; the counter clears on every state change.
REQ-012 IDLE: if rx_s==0, go to START; otherwise stay.
REQ-013 START: when counter==CLKS_PER_BIT/2-1 (mid start bit), go to DATA if rx_s==0, or back to IDLE if rx_s==1 (glitch rejected; no output).
REQ-014 DATA: when counter==CLKS_PER_BIT-1, sample rx_s into the shift register, shifting right with the new bit entering at bit 7 (LSB first), and increment the bit index; after the 8th sample, go to STOP.
REQ-015 STOP: when counter==CLKS_PER_BIT-1, if rx_s==1, load char from the shift register, pulse char_valid and go to IDLE; if rx_s==0, pulse frame_err, leave char unchanged and go to RECOVER.
REQ-016 RECOVER: stay until rx_s==1, then go to IDLE; a low line SHALL never start a new frame from RECOVER.
REQ-017 char SHALL change only on a char_valid cycle.
REQ-018 char_valid and frame_err SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-019 Latency from the raw rx falling edge of the start bit to char_valid SHALL be 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, within +/-1 cycle (154 +/-1 for the default).
REQ-020 Back-to-back frames SHALL be received: a start bit beginning on the first cycle after the stop-bit sample SHALL be detected.
REQ-021 Counter and bit index SHALL wrap only by explicit clear on state change, never by overflow.

Reset
REQ-022 While rst_n==0: state=IDLE, counter=0, bit index=0, shift register=0, char=8'h00, char_valid=0, frame_err=0, busy=0, and both synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no char_valid or frame_err pulse; after release, reception restarts at the next start bit.
REQ-024 After rst_n is released, if rx is already low, the first falling detection through the synchronizer SHALL be treated as a start bit (per REQ-013).

Verification (CLKS_PER_BIT=16)
REQ-025 Send 0x61 ('a'). Required: exactly one char_valid pulse, char=8'h61 from that cycle on, frame_err never high, pulse within 154 +/-1 cycles of the start edge.
REQ-026 Send back-to-back 0x61, 0x62, 0x30, 0x31 with no idle gap. Required: four char_valid pulses, char sequence 61, 62, 30, 31, and 160 +/-1 cycles between pulses.
REQ-027 Pulse rx low for 4 cycles, then hold high. Required: busy rises then falls, no char_valid, no frame_err, char unchanged.
REQ-028 Send 0x41 with a low stop bit, hold rx low for 40 cycles, then high, then send 0x7A. Required: one frame_err pulse, char unchanged after it, no new frame while low, then char_valid with char=8'h7A.
REQ-029 Assert rst_n low for 3 cycles during data bit 4 of 0x55, then send 0x39. Required: no pulse for 0x55, char=8'h00 after reset, then char_valid with char=8'h39.

Source files
------------

// File: rtl/char_rx.sv
// 8N1 serial character receiver: synchronizes rx, times each frame from the start-bit edge,
// and presents each correctly framed byte on char with a one-cycle char_valid pulse.
module char_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] char,
   output logic       char_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      RECOVER = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      char_q, char_d;
   logic            char_valid_q, char_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            rx_meta_q, rx_s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         char_q       <= '0;
         char_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         char_q       <= char_d;
         char_valid_q <= char_valid_d;
         frame_err_q  <= frame_err_d;
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CW'(1);
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      char_d       = char_q;
      char_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  char_d       = shift_q;
                  char_valid_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RECOVER;
               end
            end
         end
         RECOVER: begin
            // A held-low line after a bad stop bit must not be mistaken for a start bit.
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE);
      char       = char_q;
      char_valid = char_valid_q;
      frame_err  = frame_err_q;
   end

endmodule

// File: tb/tb_char_rx.sv
// Scoreboard bench for char_rx: expected bytes and start cycles are queued as frames are
// driven and compared when char_valid fires; protocol rules are checked every cycle.
module tb_char_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] char_w;
   logic       char_valid;
   logic       frame_err;
   logic       busy;

   int         n_chk  = 0;
   int         n_fail = 0;
   int         cyc    = 0;
   int         fe_cnt = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         cv_cyc[$];
   logic       prev_cv = 1'b0;
   logic       prev_fe = 1'b0;
   logic [7:0] prev_char = 8'h00;
   logic       saw_busy = 1'b0;

   char_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .char      (char_w),
      .char_valid(char_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves rx at the stop-bit level so callers can stretch a bad stop bit.
   task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit expect_it);
      rx = 1'b0;
      if (expect_it) begin
         exp_q.push_back(b);
         start_q.push_back(cyc);
      end
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = good_stop;
      tick(CPB);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
      chk("drain", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (char_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", {24'd0, char_w}, 32'hFFFF_FFFF);
            end else begin
               logic [7:0] e;
               int s, lat;
               e = exp_q.pop_front();
               s = start_q.pop_front();
               lat = cyc - s;
               chk("char", char_w, e);
               chk("latency_in_153_155", (lat >= 153 && lat <= 155), 1);
               cv_cyc.push_back(cyc);
            end
         end
         if (frame_err) fe_cnt++;
         if (char_valid || frame_err) begin
            chk("pulse_exclusive", char_valid & frame_err, 0);
            chk("pulse_single_cycle", prev_cv | prev_fe, 0);
         end
         if (char_w != prev_char) chk("char_changes_on_valid", char_valid, 1);
         if (busy) saw_busy = 1'b1;
      end
      prev_cv   = char_valid;
      prev_fe   = frame_err;
      prev_char = char_w;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0;
      rx    = 1'b1;
      tick(3);
      chk("rst_char", char_w, 8'h00);
      chk("rst_valid", char_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick(10);

      // Single character
      send_byte(8'h61, 1'b1, 1'b1);
      rx = 1'b1;
      wait_drain(200);
      tick(10);
      chk("hold_char_61", char_w, 8'h61);

      // Back-to-back characters with no idle gap
      base = cv_cyc.size();
      send_byte(8'h61, 1'b1, 1'b1);
      send_byte(8'h62, 1'b1, 1'b1);
      send_byte(8'h30, 1'b1, 1'b1);
      send_byte(8'h31, 1'b1, 1'b1);
      rx = 1'b1;
      wait_drain(200);
      chk("b2b_count", cv_cyc.size() - base, 4);
      if (cv_cyc.size() - base == 4) begin
         for (int i = base + 1; i < base + 4; i++) chk("b2b_spacing", cv_cyc[i] - cv_cyc[i-1], 160);
      end
      chk("b2b_last_char", char_w, 8'h31);

      // Short glitch is rejected
      tick(5);
      saw_busy = 1'b0;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(30);
      chk("glitch_busy_rose", saw_busy, 1);
      chk("glitch_busy_fell", busy, 0);
      chk("glitch_char", char_w, 8'h31);
      chk("glitch_no_ferr", fe_cnt, 0);

      // Bad stop bit, line held low, then recovery
      send_byte(8'h41, 1'b0, 1'b0);
      tick(40);
      chk("recover_busy_low_line", busy, 1);
      chk("ferr_count", fe_cnt, 1);
      chk("ferr_char_kept", char_w, 8'h31);
      rx = 1'b1;
      tick(10);
      chk("recover_idle", busy, 0);
      send_byte(8'h7A, 1'b1, 1'b1);
      rx = 1'b1;
      wait_drain(200);
      chk("after_ferr_char", char_w, 8'h7A);

      // Reset during data bit 4 of 0x55
      tick(5);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = (8'h55 >> i) & 8'h01;
         tick(CPB);
      end
      rx = 1'b1;
      tick(CPB / 2);
      rst_n = 1'b0;
      #1;
      chk("midrst_char", char_w, 8'h00);
      chk("midrst_busy", busy, 0);
      tick(3);
      rst_n = 1'b1;
      tick(200);
      chk("midrst_no_pulse_char", char_w, 8'h00);
      send_byte(8'h39, 1'b1, 1'b1);
      rx = 1'b1;
      wait_drain(200);
      chk("after_rst_char", char_w, 8'h39);
      tick(20);
      chk("final_ferr_count", fe_cnt, 1);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
